// File: rtl/fifo_rd_stream.sv
// Read-side drain of the synchronous FIFO: issues reads, captures the returned word one cycle later
// and presents it as a valid/ready stream through a small skid buffer. Define FIFO_RD_STREAM_STATS_EN for counters.
`timescale 1ns/1ps

module fifo_rd_stream #(
  parameter int DATA_W    = 8,
  parameter int BUF_DEPTH = 2
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               i_flush,
  input  logic                               i_fifo_empty,
  input  logic [DATA_W-1:0]                  i_fifo_rddata,
  output logic                               o_fifo_rden,
  output logic                               o_m_valid,
  input  logic                               i_m_ready,
  output logic [DATA_W-1:0]                  o_m_data,
`ifdef FIFO_RD_STREAM_STATS_EN
  output logic [$clog2(BUF_DEPTH+1)-1:0]     o_buf_count,
  output logic [31:0]                        o_word_cnt,
  output logic [31:0]                        o_stall_cnt
`else
  output logic [$clog2(BUF_DEPTH+1)-1:0]     o_buf_count
`endif
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int LVL_W = CNT_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [LVL_W-1:0] lvl_t;

  logic [DATA_W-1:0] mem_q [BUF_DEPTH];
  logic [DATA_W-1:0] mem_d [BUF_DEPTH];
  ptr_t              wr_ptr_q, wr_ptr_d;
  ptr_t              rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              inflight_q, inflight_d;
  logic              pop;
  lvl_t              level;

  // Explicit compare-and-reset so non-power-of-two depths wrap correctly.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(BUF_DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign o_m_valid   = (count_q != '0);
  assign o_m_data    = mem_q[rd_ptr_q];
  assign o_buf_count = count_q;
  assign pop         = o_m_valid & i_m_ready;

  // Occupancy after this edge if no read is issued; pop is a legal credit, which keeps full rate.
  assign level       = lvl_t'(count_q) + lvl_t'(inflight_q) - lvl_t'(pop);
  assign o_fifo_rden = rstn & ~i_flush & ~i_fifo_empty & (level < lvl_t'(BUF_DEPTH));

  // NOTE: every always_comb output gets its default first, so no path can infer a latch.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    inflight_d = o_fifo_rden;
    if (i_flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      inflight_d = 1'b0;
    end else begin
      if (inflight_q) begin
        mem_d[wr_ptr_q] = i_fifo_rddata;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({inflight_q, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: the storage is reset because o_m_data exposes the head entry and must read 0 out of reset.
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
    end
  end

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [31:0] word_cnt_q, word_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    word_cnt_d  = word_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (i_flush) begin
      word_cnt_d  = '0;
      stall_cnt_d = '0;
    end else begin
      if (pop) begin
        word_cnt_d = word_cnt_q + 32'd1;
      end
      if (o_m_valid && !i_m_ready && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      word_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      word_cnt_q  <= word_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_word_cnt  = word_cnt_q;
  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream: a queue-based FIFO model feeds the DUT, words read from it are
// expected in order at the stream output unless a flush or reset discards them.
`timescale 1ns/1ps

module tb_fifo_rd_stream;

  localparam int DATA_W    = 8;
  localparam int BUF_DEPTH = 2;
  localparam int CNT_W     = $clog2(BUF_DEPTH + 1);

  logic              clk = 1'b0;
  logic              rstn;
  logic              i_flush;
  logic              i_fifo_empty;
  logic [DATA_W-1:0] i_fifo_rddata;
  logic              o_fifo_rden;
  logic              o_m_valid;
  logic              i_m_ready;
  logic [DATA_W-1:0] o_m_data;
  logic [CNT_W-1:0]  o_buf_count;
`ifdef FIFO_RD_STREAM_STATS_EN
  logic [31:0]       o_word_cnt;
  logic [31:0]       o_stall_cnt;
`endif

  fifo_rd_stream #(.DATA_W(DATA_W), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .i_flush       (i_flush),
    .i_fifo_empty  (i_fifo_empty),
    .i_fifo_rddata (i_fifo_rddata),
    .o_fifo_rden   (o_fifo_rden),
    .o_m_valid     (o_m_valid),
    .i_m_ready     (i_m_ready),
    .o_m_data      (o_m_data),
`ifdef FIFO_RD_STREAM_STATS_EN
    .o_buf_count   (o_buf_count),
    .o_word_cnt    (o_word_cnt),
    .o_stall_cnt   (o_stall_cnt)
`else
    .o_buf_count   (o_buf_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } dchk_t;

  typedef struct {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [CNT_W-1:0]  count;
    logic              rden;
  } smp_t;

  dchk_t             dir_q[$];
  logic [DATA_W-1:0] fifo_q[$];
  logic [DATA_W-1:0] exp_q[$];
  int                checks   = 0;
  int                failures = 0;
  logic              pend_v   = 1'b0;
  logic [DATA_W-1:0] pend_w   = '0;
  logic [DATA_W-1:0] gen_w    = 8'h40;
  smp_t              smp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Directed expectations from the stimulus are compared by the monitor at its next sample point.
  task automatic expect_now(input string name, input logic [31:0] act, input logic [31:0] exp);
    dir_q.push_back('{name, act, exp});
  endtask

  // ---------------- monitor / scoreboard (samples at the falling edge) ----------------
  logic              hold_v = 1'b0;
  logic [DATA_W-1:0] hold_d = '0;
`ifdef FIFO_RD_STREAM_STATS_EN
  logic [31:0]       mdl_words  = '0;
  logic [31:0]       mdl_stalls = '0;
`endif

  always @(negedge clk) begin
    dchk_t             d;
    logic [DATA_W-1:0] w;
    while (dir_q.size() > 0) begin
      d = dir_q.pop_front();
      check(d.name, d.act, d.exp);
    end
`ifdef FIFO_RD_STREAM_STATS_EN
    if (!rstn) begin
      mdl_words  = '0;
      mdl_stalls = '0;
    end
    check("word_cnt", o_word_cnt, mdl_words);
    check("stall_cnt", o_stall_cnt, mdl_stalls);
    if (rstn) begin
      if (i_flush) begin
        mdl_words  = '0;
        mdl_stalls = '0;
      end else begin
        if (o_m_valid && i_m_ready) mdl_words = mdl_words + 1;
        if (o_m_valid && !i_m_ready && mdl_stalls != 32'hFFFF_FFFF) mdl_stalls = mdl_stalls + 1;
      end
    end
`endif
    if (!rstn) begin
      exp_q.delete();
      hold_v = 1'b0;
      pend_v = 1'b0;
    end else begin
      check("occupancy_bound", 32'(o_buf_count <= CNT_W'(BUF_DEPTH)), 1);
      check("valid_iff_nonempty", 32'(o_m_valid), 32'(o_buf_count != '0));
      if (hold_v) begin
        check("stall_hold_valid", 32'(o_m_valid), 1);
        check("stall_hold_data", 32'(o_m_data), 32'(hold_d));
      end
      if (o_m_valid && i_m_ready) begin
        check("word_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("stream_data", 32'(o_m_data), 32'(exp_q.pop_front()));
      end
      hold_v = o_m_valid & ~i_m_ready & ~i_flush;
      hold_d = o_m_data;
      if (i_flush) exp_q.delete();
      pend_v = 1'b0;
      if (o_fifo_rden) begin
        check("rden_fifo_has_data", 32'(fifo_q.size() != 0), 1);
        if (fifo_q.size() != 0) begin
          w = fifo_q.pop_front();
          exp_q.push_back(w);
          pend_v = 1'b1;
          pend_w = w;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(gen_w);
      gen_w = gen_w + 8'd1;
    end
  endtask

  // One clock cycle: apply inputs, sample the cycle's outputs, then present any word read at this edge.
  task automatic tick(input logic rdy, input logic fl);
    i_m_ready    = rdy;
    i_flush      = fl;
    i_fifo_empty = (fifo_q.size() == 0);
    #1;
    smp.valid = o_m_valid;
    smp.data  = o_m_data;
    smp.count = o_buf_count;
    smp.rden  = o_fifo_rden;
    @(posedge clk);
    #1;
    i_fifo_rddata = pend_v ? pend_w : DATA_W'($urandom);
  endtask

  task automatic pulse_reset();
    #1;
    rstn = 1'b0;
    #1;
    expect_now("rst_valid", 32'(o_m_valid), 0);
    expect_now("rst_count", 32'(o_buf_count), 0);
    expect_now("rst_rden", 32'(o_fifo_rden), 0);
    @(posedge clk);
    #1;
    i_fifo_rddata = DATA_W'($urandom);
    rstn          = 1'b1;
  endtask

  task automatic fresh();
    fifo_q.delete();
    pulse_reset();
  endtask

  task automatic drain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      tick(1'b1, 1'b0);
      done = (fifo_q.size() == 0) && (exp_q.size() == 0) && !smp.valid && !pend_v;
    end
    expect_now(name, 32'(done), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int               rden_cnt;
    int               gaps;
    int               xfers;
    int               cyc;
    logic [DATA_W-1:0] first_w;
    logic [DATA_W-1:0] next_w;
    bit               seen;
    logic             exp_rden  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic             exp_valid [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0]       exp_data  [6] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};

    rstn          = 1'b0;
    i_flush       = 1'b0;
    i_m_ready     = 1'b1;
    i_fifo_empty  = 1'b0;
    i_fifo_rddata = '0;
    #2;
    expect_now("reset_valid", 32'(o_m_valid), 0);
    expect_now("reset_data", 32'(o_m_data), 0);
    expect_now("reset_count", 32'(o_buf_count), 0);
    expect_now("reset_rden", 32'(o_fifo_rden), 0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;

    // Latency: three known words, continuous ready.
    fifo_q.push_back(8'h11);
    fifo_q.push_back(8'h22);
    fifo_q.push_back(8'h33);
    for (int k = 0; k < 6; k++) begin
      tick(1'b1, 1'b0);
      expect_now($sformatf("lat_rden_c%0d", k), 32'(smp.rden), 32'(exp_rden[k]));
      expect_now($sformatf("lat_valid_c%0d", k), 32'(smp.valid), 32'(exp_valid[k]));
      if (exp_valid[k]) expect_now($sformatf("lat_data_c%0d", k), 32'(smp.data), 32'(exp_data[k]));
    end

    // Back-pressure: 8 words, ready low, then release.
    fresh();
    first_w  = gen_w;
    push_words(8);
    rden_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick(1'b0, 1'b0);
      rden_cnt += int'(smp.rden);
    end
    expect_now("bp_rden_pulses", 32'(rden_cnt), BUF_DEPTH);
    expect_now("bp_count", 32'(smp.count), BUF_DEPTH);
    expect_now("bp_head_data", 32'(smp.data), 32'(first_w));
    gaps = 0;
    for (int k = 0; k < 8; k++) begin
      tick(1'b1, 1'b0);
      gaps += int'(!smp.valid);
    end
    expect_now("bp_no_gaps", 32'(gaps), 0);
    tick(1'b1, 1'b0);
    expect_now("bp_valid_after_last", 32'(smp.valid), 0);

    // Ready toggling with a FIFO that never runs dry.
    fresh();
    push_words(4);
    xfers = 0;
    for (int k = 0; k < 100 && xfers < 20; k++) begin
      push_words(1);
      tick(k[0] == 1'b0, 1'b0);
      xfers += int'(smp.valid && i_m_ready);
    end
    expect_now("toggle_transfers", 32'(xfers), 20);
    drain("toggle_drain");

    // Flush with a full skid buffer.
    fresh();
    push_words(8);
    repeat (4) tick(1'b0, 1'b0);
    expect_now("flush_pre_count", 32'(smp.count), BUF_DEPTH);
    tick(1'b0, 1'b1);
    expect_now("flush_rden_low", 32'(smp.rden), 0);
    tick(1'b0, 1'b0);
    expect_now("flush_valid", 32'(smp.valid), 0);
    expect_now("flush_count", 32'(smp.count), 0);
    drain("flush_full_drain");

    // Flush while streaming with a word in flight.
    fresh();
    push_words(8);
    repeat (3) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    expect_now("flush2_rden_low", 32'(smp.rden), 0);
    tick(1'b1, 1'b0);
    expect_now("flush2_valid", 32'(smp.valid), 0);
    expect_now("flush2_count", 32'(smp.count), 0);
    drain("flush_stream_drain");

    // Asynchronous reset mid-stream; the stream resumes with the next FIFO word.
    fresh();
    push_words(10);
    repeat (4) tick(1'b1, 1'b0);
    i_fifo_empty = 1'b0;
    pulse_reset();
    next_w = fifo_q[0];
    seen   = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick(1'b1, 1'b0);
      if (smp.valid) begin
        seen = 1'b1;
        expect_now("rst_resume_word", 32'(smp.data), 32'(next_w));
      end
    end
    expect_now("rst_resume_seen", 32'(seen), 1);
    drain("rst_drain");

`ifdef FIFO_RD_STREAM_STATS_EN
    fresh();
    push_words(5);
    repeat (5) tick(1'b0, 1'b0);
    repeat (8) tick(1'b1, 1'b0);
    expect_now("stats_words", o_word_cnt, 5);
    expect_now("stats_stalls", o_stall_cnt, 3);
    tick(1'b0, 1'b1);
    expect_now("stats_words_flush", o_word_cnt, 0);
    expect_now("stats_stalls_flush", o_stall_cnt, 0);
`endif

    // Randomized traffic, back-pressure and occasional flushes.
    fresh();
    cyc = 0;
    repeat (600) begin
      if ($urandom_range(0, 99) < 45) push_words(int'($urandom_range(1, 2)));
      tick(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 2));
      cyc++;
    end
    drain("random_drain");

    repeat (2) tick(1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
